// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem handshake, show-ahead prefetch FIFO.
// Optional stall/flush statistics counters are enabled with `define FETCH_STATS_EN.
module if_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_out
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t state, state_next;

  logic [31:0]      fetch_pc;
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_after_pop, count_next;
  logic             pop, push;

  assign valid           = (count != '0);
  assign pop             = valid && !freeze && !branch_taken;
  assign push            = (state == REQ) && imem_ready && !branch_taken;
  assign count_after_pop = count - CNT_W'(pop);
  assign count_next      = count_after_pop + CNT_W'(push);

  assign imem_addr   = fetch_pc;
  assign instruction = valid ? instr_mem[rd_ptr] : 32'h0;
  assign pc_out      = valid ? (pc_mem[rd_ptr] + 32'd4) : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // DROP swallows the completion of the access abandoned by a branch while addressing the new target.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      IDLE: begin
        if (branch_taken || (count_after_pop < DEPTH_C)) state_next = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (branch_taken)    state_next = imem_ready ? REQ : DROP;
        else if (imem_ready) state_next = (count_next < DEPTH_C) ? REQ : IDLE;
      end
      DROP: begin
        imem_req = 1'b1;
        if (!branch_taken && imem_ready) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (branch_taken) begin
      fetch_pc <= branch_addr;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // Storage needs no reset: entries are only visible through a nonzero count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!valid && !freeze) stall_cnt <= stall_cnt + 32'd1;
      if (branch_taken && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
